// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source synchroniser, edge/level capture, sticky pending,
// enable mask, registered lowest-index priority encode and a small register window.
module irq_ctrl #(
  parameter int          N_SRC        = 16,
  parameter int          SYNC_STAGES  = 2,
  parameter logic [31:0] RESET_ENABLE = 32'h0,
  parameter logic [31:0] RESET_MODE   = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             wen,
  input  logic [2:0]       waddr,
  input  logic [31:0]      wdata,
  input  logic             ren,
  input  logic [2:0]       raddr,
  output logic [31:0]      rdata,
  input  logic             ack,
  input  logic [4:0]       ack_id,
  output logic [N_SRC-1:0] irq_vec,
  output logic             irq_any,
  output logic [4:0]       irq_id
);

  typedef enum logic [2:0] {
    REG_PENDING = 3'd0,
    REG_ENABLE  = 3'd1,
    REG_MODE    = 3'd2,
    REG_STATUS  = 3'd3,
    REG_SOFT    = 3'd4
  } reg_e;

  localparam logic [N_SRC-1:0] EN_RST   = RESET_ENABLE[N_SRC-1:0];
  localparam logic [N_SRC-1:0] MODE_RST = RESET_MODE[N_SRC-1:0];

  logic [N_SRC-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_q [SYNC_STAGES];
      logic [N_SRC-1:0] sync_d [SYNC_STAGES];

      always_comb begin
        sync_d[0] = src;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      end

      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours, independent of block order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] irq_vec_q, irq_vec_d;
  logic             irq_any_q, irq_any_d;
  logic [4:0]       irq_id_q, irq_id_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_SRC-1:0] ack_vec, w1c_vec, soft_vec, edge_next, masked;
  logic [31:0]      rd_val;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a signal unassigned, which would infer a latch.
    ack_vec  = '0;
    w1c_vec  = '0;
    soft_vec = '0;
    irq_id_d = '0;
    rd_val   = '0;

    for (int i = 0; i < N_SRC; i++) ack_vec[i] = ack && (ack_id == 5'(i));
    if (wen && waddr == REG_PENDING) w1c_vec  = wdata[N_SRC-1:0];
    if (wen && waddr == REG_SOFT)    soft_vec = wdata[N_SRC-1:0];

    // Edge bits: a set in the same cycle as any clear wins.
    edge_next = (s & ~prev_q) | soft_vec | (pend_q & ~(w1c_vec | ack_vec));
    pend_d    = (mode_q & edge_next) | (~mode_q & s);
    prev_d    = s;
    en_d      = (wen && waddr == REG_ENABLE) ? wdata[N_SRC-1:0] : en_q;
    mode_d    = (wen && waddr == REG_MODE)   ? wdata[N_SRC-1:0] : mode_q;

    masked    = pend_q & en_q;
    irq_vec_d = masked;
    irq_any_d = |masked;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) irq_id_d = 5'(i);
    end

    case (reg_e'(raddr))
      REG_PENDING: rd_val = 32'(pend_q);
      REG_ENABLE:  rd_val = 32'(en_q);
      REG_MODE:    rd_val = 32'(mode_q);
      REG_STATUS:  rd_val = {26'b0, irq_any_q, irq_id_q};
      default:     rd_val = '0;
    endcase
    rdata_d = ren ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pend_q    <= '0;
      en_q      <= EN_RST;
      mode_q    <= MODE_RST;
      irq_vec_q <= '0;
      irq_any_q <= 1'b0;
      irq_id_q  <= '0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      irq_vec_q <= irq_vec_d;
      irq_any_q <= irq_any_d;
      irq_id_q  <= irq_id_d;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_vec = irq_vec_q;
  assign irq_any = irq_any_q;
  assign irq_id  = irq_id_q;
  assign rdata   = rdata_q;

endmodule
